// File: rtl/demux_route_ctrl.sv
// Sequencing stage for the demux tree: accepts routed words and drives Din/S from
// registers for HOLD cycles, then blanks Din for GAP cycles before taking the next word.
module demux_route_ctrl #(
  parameter int unsigned DW    = 1,
  parameter int unsigned SEL_W = 3,
  parameter int unsigned CH    = 8,
  parameter int unsigned HOLD  = 2,
  parameter int unsigned GAP   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  input  logic [SEL_W-1:0] in_dest,
  input  logic             sweep,
  input  logic             sweep_clr,
  output logic [DW-1:0]    Dout,
  output logic [SEL_W-1:0] S,
  output logic             out_valid,
  output logic             busy,
  output logic             err
);

  localparam int unsigned CNT_MAX = (HOLD > GAP) ? HOLD : GAP;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_GAP} state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [DW-1:0]    r_dout, w_dout_nxt;
  logic [SEL_W-1:0] r_s, w_s_nxt;
  logic [SEL_W-1:0] r_ptr, w_ptr_nxt;
  logic             r_out_valid, w_out_valid_nxt;
  logic             r_in_ready;
  logic             r_busy;
  logic             r_err, w_err_nxt;

  logic             w_accept;
  logic [SEL_W-1:0] w_dest;
  logic             w_in_range;

  // A coincident clear redirects a sweep-mode word to channel 0.
  assign w_accept   = in_valid && r_in_ready;
  assign w_dest     = sweep ? (sweep_clr ? '0 : r_ptr) : in_dest;
  assign w_in_range = 32'(w_dest) < CH;

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_dout_nxt      = r_dout;
    w_s_nxt         = r_s;
    w_out_valid_nxt = r_out_valid;
    w_err_nxt       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_dout_nxt      = '0;
        w_out_valid_nxt = 1'b0;
        if (w_accept) begin
          if (w_in_range) begin
            w_dout_nxt      = in_data;
            w_s_nxt         = w_dest;
            w_out_valid_nxt = 1'b1;
            w_cnt_nxt       = CNT_W'(HOLD - 1);
            w_state_nxt     = S_DRIVE;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      S_DRIVE: begin
        if (r_cnt == '0) begin
          w_dout_nxt      = '0;
          w_out_valid_nxt = 1'b0;
          if (GAP > 0) begin
            w_cnt_nxt   = CNT_W'(GAP - 1);
            w_state_nxt = S_GAP;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_GAP: begin
        w_dout_nxt      = '0;
        w_out_valid_nxt = 1'b0;
        if (r_cnt == '0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt     = S_IDLE;
        w_dout_nxt      = '0;
        w_out_valid_nxt = 1'b0;
      end
    endcase
  end

  // Sweep pointer: clear wins, and a clear that coincides with a sweep accept leaves ptr at 1.
  always_comb begin
    w_ptr_nxt = r_ptr;
    if (sweep_clr) begin
      w_ptr_nxt = (w_accept && sweep) ? SEL_W'(1) : '0;
    end else if (w_accept && sweep && w_in_range) begin
      w_ptr_nxt = (r_ptr == SEL_W'(CH - 1)) ? '0 : r_ptr + SEL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_dout      <= '0;
      r_s         <= '0;
      r_ptr       <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_dout      <= w_dout_nxt;
      r_s         <= w_s_nxt;
      r_ptr       <= w_ptr_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_in_ready  <= (w_state_nxt == S_IDLE);
      r_busy      <= (w_state_nxt != S_IDLE);
      r_err       <= w_err_nxt;
    end
  end

  assign in_ready  = r_in_ready;
  assign Dout      = r_dout;
  assign S         = r_s;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign err       = r_err;

endmodule

// File: tb/tb_demux_route_ctrl.sv
// Directed bench for demux_route_ctrl: default build, a CH=6 build for range rejects,
// and a HOLD=1/GAP=0 build for back-to-back throughput.
module tb_demux_route_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance A: defaults (CH=8, HOLD=2, GAP=1)
  logic       a_vld, a_rdy, a_data, a_sw, a_clr, a_dout, a_ov, a_busy, a_err;
  logic [2:0] a_dest, a_s;
  // Instance B: CH=6
  logic       b_vld, b_rdy, b_data, b_sw, b_clr, b_dout, b_ov, b_busy, b_err;
  logic [2:0] b_dest, b_s;
  // Instance C: HOLD=1, GAP=0
  logic       c_vld, c_rdy, c_data, c_sw, c_clr, c_dout, c_ov, c_busy, c_err;
  logic [2:0] c_dest, c_s;

  demux_route_ctrl u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_vld), .in_ready(a_rdy), .in_data(a_data),
    .in_dest(a_dest), .sweep(a_sw), .sweep_clr(a_clr), .Dout(a_dout), .S(a_s),
    .out_valid(a_ov), .busy(a_busy), .err(a_err));

  demux_route_ctrl #(.CH(6)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_vld), .in_ready(b_rdy), .in_data(b_data),
    .in_dest(b_dest), .sweep(b_sw), .sweep_clr(b_clr), .Dout(b_dout), .S(b_s),
    .out_valid(b_ov), .busy(b_busy), .err(b_err));

  demux_route_ctrl #(.HOLD(1), .GAP(0)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_vld), .in_ready(c_rdy), .in_data(c_data),
    .in_dest(c_dest), .sweep(c_sw), .sweep_clr(c_clr), .Dout(c_dout), .S(c_s),
    .out_valid(c_ov), .busy(c_busy), .err(c_err));

  // Expected vector layout: {in_ready, Dout, S[2:0], out_valid, busy, err}
  typedef struct {
    logic       vld;
    logic       data;
    logic [2:0] dest;
    logic       sw;
    logic       clr;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl [13];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [7:0] obs_a();
    return {a_rdy, a_dout, a_s, a_ov, a_busy, a_err};
  endfunction
  function automatic logic [7:0] obs_b();
    return {b_rdy, b_dout, b_s, b_ov, b_busy, b_err};
  endfunction
  function automatic logic [7:0] obs_c();
    return {c_rdy, c_dout, c_s, c_ov, c_busy, c_err};
  endfunction

  task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got rdy,dout,s,ov,busy,err=%b want %b", nm, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_a(input logic vld, input logic data, input logic [2:0] dest,
                         input logic sw, input logic clr);
    a_vld = vld; a_data = data; a_dest = dest; a_sw = sw; a_clr = clr;
  endtask

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'b1_0_000_0_0_0};
    tbl[1]  = '{1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 8'b0_1_101_1_1_0};
    tbl[2]  = '{1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'b0_1_101_1_1_0};
    tbl[3]  = '{1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'b0_0_101_0_1_0};
    tbl[4]  = '{1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'b1_0_101_0_0_0};
    tbl[5]  = '{1'b1, 1'b1, 3'd3, 1'b1, 1'b0, 8'b0_1_000_1_1_0};
    tbl[6]  = '{1'b1, 1'b1, 3'd3, 1'b1, 1'b0, 8'b0_1_000_1_1_0};
    tbl[7]  = '{1'b1, 1'b1, 3'd3, 1'b1, 1'b0, 8'b0_0_000_0_1_0};
    tbl[8]  = '{1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'b1_0_000_0_0_0};
    tbl[9]  = '{1'b1, 1'b0, 3'd7, 1'b1, 1'b0, 8'b0_0_001_1_1_0};
    tbl[10] = '{1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'b0_0_001_1_1_0};
    tbl[11] = '{1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'b0_0_001_0_1_0};
    tbl[12] = '{1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 8'b1_0_001_0_0_0};

    rst_n = 1'b0;
    drive_a(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    b_vld = 1'b0; b_data = 1'b0; b_dest = 3'd0; b_sw = 1'b0; b_clr = 1'b0;
    c_vld = 1'b0; c_data = 1'b0; c_dest = 3'd0; c_sw = 1'b0; c_clr = 1'b0;

    tick();
    chk("reset_a", 0, obs_a(), 8'b0_0_000_0_0_0);
    chk("reset_b", 0, obs_b(), 8'b0_0_000_0_0_0);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      drive_a(tbl[i].vld, tbl[i].data, tbl[i].dest, tbl[i].sw, tbl[i].clr);
      tick();
      chk("tbl", i, obs_a(), tbl[i].exp);
    end

    // Ten back-to-back sweep words, in_valid held high; S wraps 7 -> 0.
    drive_a(1'b1, 1'b1, 3'd6, 1'b1, 1'b0);
    for (int w = 0; w < 10; w++) begin
      for (int ph = 0; ph < 4; ph++) begin
        tick();
        case (ph)
          0, 1:    chk("sweep", w * 4 + ph, obs_a(), {2'b01, 3'(w % 8), 3'b110});
          2:       chk("sweep", w * 4 + ph, obs_a(), {2'b00, 3'(w % 8), 3'b010});
          default: chk("sweep", w * 4 + ph, obs_a(), {2'b10, 3'(w % 8), 3'b000});
        endcase
      end
    end

    // Two more sweep words bring ptr to 4, then clear coincides with a sweep accept.
    for (int k = 0; k < 8; k++) tick();
    chk("pre_clr", 0, obs_a(), 8'b1_0_011_0_0_0);
    drive_a(1'b1, 1'b1, 3'd6, 1'b1, 1'b1);
    tick();
    chk("clr_accept", 0, obs_a(), 8'b0_1_000_1_1_0);
    drive_a(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) tick();
    drive_a(1'b1, 1'b1, 3'd6, 1'b1, 1'b0);
    tick();
    chk("after_clr", 0, obs_a(), 8'b0_1_001_1_1_0);
    drive_a(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) tick();

    // CH=6: out-of-range destinations are dropped with an err pulse.
    b_vld = 1'b1; b_data = 1'b1; b_dest = 3'd7;
    tick();
    chk("range_b", 0, obs_b(), 8'b1_0_000_0_0_1);
    b_dest = 3'd6;
    tick();
    chk("range_b", 1, obs_b(), 8'b1_0_000_0_0_1);
    b_dest = 3'd5;
    tick();
    chk("range_b", 2, obs_b(), 8'b0_1_101_1_1_0);
    b_vld = 1'b0;
    tick();
    chk("range_b", 3, obs_b(), 8'b0_1_101_1_1_0);

    // HOLD=1, GAP=0: continuous words give out_valid on alternate cycles.
    c_vld = 1'b1; c_data = 1'b1;
    for (int i = 0; i < 6; i++) begin
      c_dest = 3'(i + 1);
      tick();
      if (i % 2 == 0) chk("burst_c", i, obs_c(), {2'b01, 3'(i + 1), 3'b110});
      else            chk("burst_c", i, obs_c(), {2'b10, 3'(i), 3'b000});
    end
    c_vld = 1'b0;

    // Asynchronous reset mid-DRIVE on instance A.
    drive_a(1'b1, 1'b1, 3'd3, 1'b0, 1'b0);
    tick();
    chk("pre_rst", 0, obs_a(), 8'b0_1_011_1_1_0);
    drive_a(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk("async_rst", 0, obs_a(), 8'b0_0_000_0_0_0);
    tick();
    chk("held_rst", 0, obs_a(), 8'b0_0_000_0_0_0);
    rst_n = 1'b1;
    tick();
    chk("post_rst", 0, obs_a(), 8'b1_0_000_0_0_0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux_route_ctrl.md
Name: demux_route_ctrl

Overview:
- Upstream sequencing stage for the 1x2 / 1x4 / 1x8 demultiplexer tree.
- Accepts data words over a valid/ready handshake with either an explicit destination channel or an auto-incrementing sweep pointer.
- Drives the tree's data input and select lines from registers, holding them stable for a programmable number of cycles, then inserting a blanking gap.
- Provides a clean, glitch-free stimulus source for the combinational demux.

Parameters:
- DW, 1, data width driven onto the demux data input.
- SEL_W, 3, select width (1x8 tree).
- CH, 8, number of valid channels, 2 to 2**SEL_W.
- HOLD, 2, cycles Dout/S/out_valid stay asserted per word, minimum 1.
- GAP, 1, blanking cycles after HOLD with Dout forced 0, 0 allowed.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream word available.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  DW  word to route.
- in_dest  input  SEL_W  destination channel, used when sweep=0.
- sweep  input  1  1 = route to internal pointer, ignore in_dest.
- sweep_clr  input  1  synchronous clear of the sweep pointer.
- Dout  output  DW  registered data to the demux Din.
- S  output  SEL_W  registered select to the demux S.
- out_valid  output  1  Dout/S carry a live word.
- busy  output  1  state is not IDLE.
- err  output  1  one-cycle pulse on a rejected out-of-range destination.

Behaviour:
- Reset (async, rst_n=0):
  - State is IDLE.
  - Dout=0, S=0, out_valid=0, err=0, ptr=0.
  - in_ready=0 while reset is asserted; in_ready rises on the first clock edge after release.
  - All outputs are registered.
- Accept condition: in_valid && in_ready at a rising edge.
  - Mode, destination and data are sampled only at accept.
- States IDLE, DRIVE, GAP; a counter cnt tracks HOLD and GAP.
- IDLE:
  - in_ready=1, out_valid=0, Dout=0; S keeps its last value.
  - On accept with resolved dest < CH:
    - Dout<=in_data.
    - S<=dest.
    - out_valid<=1.
    - cnt<=HOLD-1.
    - in_ready<=0.
    - Go to DRIVE.
  - Resolved dest is ptr when sweep=1, otherwise in_dest.
  - On accept with dest >= CH: the word is consumed and dropped, err pulses for 1 cycle, state stays IDLE, and ptr does not advance.
- DRIVE:
  - Dout, S and out_valid are held.
  - Decrement cnt each cycle.
  - When cnt==0: if GAP>0, go to GAP with out_valid<=0, Dout<=0, S held, cnt<=GAP-1; if GAP==0, go to IDLE with in_ready<=1.
  - out_valid is high for exactly HOLD cycles per word.
- GAP:
  - Dout=0, out_valid=0.
  - When cnt==0, go to IDLE and set in_ready<=1.
- Throughput: one word per HOLD+GAP+1 cycles. Latency is 1 cycle: a word accepted at edge k appears on Dout/S after edge k.
- Sweep pointer:
  - ptr advances (ptr+1) mod CH on each in-range sweep-mode accept, wrapping CH-1 -> 0.
  - sweep_clr sets ptr<=0 in any state.
  - If sweep_clr coincides with a sweep accept, clr wins: the word routes to channel 0 and ptr<=1.
  - Direct-mode accepts never move ptr.
- in_valid deasserted while busy is ignored; no buffering, and the upstream holds its word until in_ready.
- Asserting reset mid-DRIVE or mid-GAP immediately forces all reset values, and the in-flight word is lost.
- busy equals (state != IDLE).

Test Plan:
- Reset release, then direct word in_data=1, in_dest=5 -> one cycle after accept Dout=1, S=5, out_valid=1 for 2 cycles, then 1 gap cycle with Dout=0, then in_ready=1.
- Sweep=1 with 10 back-to-back words, in_valid held high -> S sequence 0,1,...,7,0,1; each word spaced 4 cycles (HOLD+GAP+1); ptr wraps.
- CH=6 build, direct in_dest=7 -> err pulses 1 cycle, out_valid stays 0, state stays IDLE, and the next word is accepted the following cycle.
- sweep_clr asserted on the same edge as a sweep accept with ptr=4 -> S=0, and the next sweep word routes to S=1.
- rst_n dropped for 1 cycle mid-DRIVE -> Dout=0, S=0, out_valid=0, busy=0 asynchronously; in_ready returns to 1 after release.
- GAP=0, HOLD=1 build with continuous words -> out_valid high 1 of every 2 cycles, no blank cycle between DRIVE and IDLE.
